mem_sum_fnd_ctrl: RTL

//  Downstream display stage for the memory-based sum datapath: takes the 8-bit

---
 rtl/fnd_pkg.sv | 53 +++++
 rtl/bin2bcd_8.sv | 36 +++
 rtl/mem_sum_fnd_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
//   Shared constants for the Basys3 4-digit 7-segment (FND) display stages.
//   Segment bytes are ordered {dp,g,f,e,d,c,b,a} and are active-low, so a
//   cleared bit lights that segment.
//   Contents: FONT_0..FONT_9, FONT_BLANK, DP_BIT, SEG_W, digit slot enum and
//   a decimal-digit to font helper.
// ---------------------------------------------------------------------------
package fnd_pkg;

   localparam int unsigned SEG_W  = 8;  // {dp,g,f,e,d,c,b,a}
   localparam int unsigned DP_BIT = 7;  // decimal point position in the font byte

   localparam logic [SEG_W-1:0] FONT_0     = 8'hC0;
   localparam logic [SEG_W-1:0] FONT_1     = 8'hF9;
   localparam logic [SEG_W-1:0] FONT_2     = 8'hA4;
   localparam logic [SEG_W-1:0] FONT_3     = 8'hB0;
   localparam logic [SEG_W-1:0] FONT_4     = 8'h99;
   localparam logic [SEG_W-1:0] FONT_5     = 8'h92;
   localparam logic [SEG_W-1:0] FONT_6     = 8'h82;
   localparam logic [SEG_W-1:0] FONT_7     = 8'hF8;
   localparam logic [SEG_W-1:0] FONT_8     = 8'h80;
   localparam logic [SEG_W-1:0] FONT_9     = 8'h90;
   localparam logic [SEG_W-1:0] FONT_BLANK = 8'hFF;

   // Scan slot meaning; slot 0 is the rightmost digit.
   typedef enum logic [1:0] {
      DigOnes     = 2'd0,
      DigTens     = 2'd1,
      DigHundreds = 2'd2,
      DigUnused   = 2'd3
   } digit_e;

   // Decimal digit to font, dp off. Non-decimal codes show blank.
   function automatic logic [SEG_W-1:0] font_of(input logic [3:0] dig);
      logic [SEG_W-1:0] f;
      case (dig)
         4'd0:    f = FONT_0;
         4'd1:    f = FONT_1;
         4'd2:    f = FONT_2;
         4'd3:    f = FONT_3;
         4'd4:    f = FONT_4;
         4'd5:    f = FONT_5;
         4'd6:    f = FONT_6;
         4'd7:    f = FONT_7;
         4'd8:    f = FONT_8;
         4'd9:    f = FONT_9;
         default: f = FONT_BLANK;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/bin2bcd_8.sv
// ---------------------------------------------------------------------------
// bin2bcd_8
//   Combinational 8-bit binary to BCD converter (double dabble).
//   Ports:
//     i_bin   in  8  unsigned binary value 0..255
//     o_hund  out 2  hundreds digit 0..2
//     o_tens  out 4  tens digit 0..9
//     o_ones  out 4  ones digit 0..9
// ---------------------------------------------------------------------------
module bin2bcd_8 (
   input  logic [7:0] i_bin,
   output logic [1:0] o_hund,
   output logic [3:0] o_tens,
   output logic [3:0] o_ones
);

   // Scratch layout: {hundreds[3:0], tens[3:0], ones[3:0], binary[7:0]}
   logic [19:0] w_scr;

   always_comb begin
      w_scr = {12'd0, i_bin};
      for (int i = 0; i < 8; i++) begin
         // Pre-correct any BCD nibble >= 5 so the following shift carries in decimal
         if (w_scr[11:8]  >= 4'd5) w_scr[11:8]  = w_scr[11:8]  + 4'd3;
         if (w_scr[15:12] >= 4'd5) w_scr[15:12] = w_scr[15:12] + 4'd3;
         if (w_scr[19:16] >= 4'd5) w_scr[19:16] = w_scr[19:16] + 4'd3;
         w_scr = w_scr << 1;
      end
   end

   // 255 max, so hundreds never exceeds 2 and fits in two bits
   assign o_hund = w_scr[17:16];
   assign o_tens = w_scr[15:12];
   assign o_ones = w_scr[11:8];

endmodule

// File: rtl/mem_sum_fnd_ctrl.sv
// ---------------------------------------------------------------------------
// mem_sum_fnd_ctrl
//   Shows the 8-bit sum result in decimal on the 4-digit 7-segment display.
//   Digits are time-multiplexed one per prescaler tick; the value is captured
//   once per scan frame so a frame never mixes two values. Leading zeros can
//   be blanked, and the ones-digit decimal point flashes for FLASH_FRAMES
//   frames after the captured value changes.
//   Ports:
//     iClk      in   1  system clock
//     iRst      in   1  synchronous active-high reset
//     iData     in   8  unsigned result from the sum datapath
//     oFndCom   out  4  digit enables, active-low, [0] = ones digit
//     oFndFont  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module mem_sum_fnd_ctrl
   import fnd_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 100_000,
   parameter int unsigned BLANK_LZ     = 1,
   parameter int unsigned FLASH_FRAMES = 64
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [7:0]       iData,
   output logic [3:0]       oFndCom,
   output logic [SEG_W-1:0] oFndFont
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   localparam int unsigned FL_W  = $clog2(FLASH_FRAMES + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(FLASH_FRAMES);
   localparam bit               BLANK_EN = (BLANK_LZ != 0);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [7:0]       r_data;
   logic [FL_W-1:0]  r_flash;
   logic [3:0]       r_com;
   logic [SEG_W-1:0] r_font;

   logic             w_tick;
   logic             w_capture;
   logic [FL_W-1:0]  w_flash_nxt;
   logic [1:0]       w_hund;
   logic [3:0]       w_tens;
   logic [3:0]       w_ones;
   logic [SEG_W-1:0] w_font;

   assign w_tick    = (r_cnt == CNT_MAX);
   // Capture on the edge that wraps the scan back to digit 0
   assign w_capture = w_tick && (r_idx == 2'd3);

   always_comb begin
      w_flash_nxt = r_flash;
      if (iData != r_data) begin
         w_flash_nxt = FL_LOAD;
      end else if (r_flash != '0) begin
         w_flash_nxt = r_flash - 1'b1;
      end
   end

   bin2bcd_8 u_bin2bcd (
      .i_bin  (r_data),
      .o_hund (w_hund),
      .o_tens (w_tens),
      .o_ones (w_ones)
   );

   // Digit mux for the slot currently selected by r_idx
   always_comb begin
      w_font = FONT_BLANK;
      unique case (digit_e'(r_idx))
         DigOnes: begin
            w_font = font_of(w_ones);
            if (r_flash != '0) w_font[DP_BIT] = 1'b0;
         end
         DigTens: begin
            if (!(BLANK_EN && (w_hund == 2'd0) && (w_tens == 4'd0))) begin
               w_font = font_of(w_tens);
            end
         end
         DigHundreds: begin
            if (!(BLANK_EN && (w_hund == 2'd0))) begin
               w_font = font_of({2'b00, w_hund});
            end
         end
         DigUnused: w_font = FONT_BLANK;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_data  <= 8'd0;
         r_flash <= '0;
         r_com   <= 4'b1111;
         r_font  <= FONT_BLANK;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) r_idx <= r_idx + 2'd1;
         if (w_capture) begin
            r_data  <= iData;
            r_flash <= w_flash_nxt;
         end
         // Registered from current state, so outputs trail r_idx by one clock
         r_com  <= ~(4'b0001 << r_idx);
         r_font <= w_font;
      end
   end

   assign oFndCom  = r_com;
   assign oFndFont = r_font;

endmodule
